fpga_rst_seq: RTL and testbench

FPGA_RST_SEQ -- requirements
Module: fpga_rst_seq

---
 rtl/fpga_rst_seq.sv | 143 ++++++++++++++
 tb/tb_fpga_rst_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_rst_seq.sv
// Power-up / soft-reset sequencer driving PCIe PERST#, Ethernet PHY reset and CPU core reset.
// Optional calibration-wait timeout into FAULT: define FPGA_RST_SEQ_CALIB_TO_EN.
module fpga_rst_seq #(
    parameter int unsigned PERST_CYC = 5000000,
    parameter int unsigned PHY_CYC   = 500000,
    parameter int unsigned CALIB_TO  = 16777215
) (
    input  logic       sys_clk_i,
    input  logic       sys_rstn,
    input  logic       enable,
    input  logic       cpu_go,
    input  logic       cpu_rst_req,
    input  logic       calib_done,
    output logic       perst_n,
    output logic       phy_rstn,
    output logic       cpu_rstn,
    output logic [2:0] seq_state,
    output logic       calib_timeout
);
    typedef enum logic [2:0] {
        StReset = 3'd0,
        StPerst = 3'd1,
        StCalib = 3'd2,
        StArmed = 3'd3,
        StPhy   = 3'd4,
        StRun   = 3'd5,
        StFault = 3'd6
    } state_e;

    localparam logic [23:0] PerstLast = 24'(PERST_CYC - 1);
    localparam logic [23:0] PhyLast   = 24'(PHY_CYC - 1);
    localparam logic [23:0] CalibLast = 24'(CALIB_TO - 1);
    localparam logic [23:0] CntMax    = 24'hFF_FFFF;

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [1:0]  calib_sync_q;
    logic        calib_s;
    logic        perst_d, phy_d, cpu_d;
    logic        perst_q, phy_q, cpu_q;

    always_ff @(posedge sys_clk_i or negedge sys_rstn) begin
        if (!sys_rstn) begin
            calib_sync_q <= 2'b00;
        end else begin
            calib_sync_q <= {calib_sync_q[0], calib_done};
        end
    end

    assign calib_s = calib_sync_q[1];

    // Outputs are registered from the next state so they change together with seq_state.
    always_ff @(posedge sys_clk_i or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q <= StReset;
            cnt_q   <= 24'd0;
            perst_q <= 1'b0;
            phy_q   <= 1'b0;
            cpu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perst_q <= perst_d;
            phy_q   <= phy_d;
            cpu_q   <= cpu_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StReset;
        end else begin
            case (state_q)
                StReset: state_d = StPerst;
                StPerst: if (cnt_q == PerstLast) state_d = StCalib;
                StCalib: begin
                    if (calib_s) begin
                        state_d = StArmed;
`ifdef FPGA_RST_SEQ_CALIB_TO_EN
                    end else if (cnt_q == CalibLast) begin
                        state_d = StFault;
`endif
                    end
                end
                StArmed: begin
                    if (!calib_s)    state_d = StCalib;
                    else if (cpu_go) state_d = StPhy;
                end
                StPhy: begin
                    if (!calib_s)             state_d = StCalib;
                    else if (cnt_q == PhyLast) state_d = StRun;
                end
                StRun: begin
                    if (!calib_s)         state_d = StCalib;
                    else if (cpu_rst_req) state_d = StArmed;
                end
                StFault: state_d = StFault;
                default: state_d = StReset;
            endcase
        end

        if (state_d != state_q) begin
            cnt_d = 24'd0;
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    always_comb begin
        perst_d = (state_d != StReset) && (state_d != StPerst);
        phy_d   = (state_d == StPhy) || (state_d == StRun);
        cpu_d   = (state_d == StRun);
    end

    assign perst_n   = perst_q;
    assign phy_rstn  = phy_q;
    assign cpu_rstn  = cpu_q;
    assign seq_state = state_q;

`ifdef FPGA_RST_SEQ_CALIB_TO_EN
    logic timeout_q;

    // Sticky: only sys_rstn clears it, leaving FAULT through enable does not.
    always_ff @(posedge sys_clk_i or negedge sys_rstn) begin
        if (!sys_rstn) begin
            timeout_q <= 1'b0;
        end else if (state_d == StFault) begin
            timeout_q <= 1'b1;
        end
    end

    assign calib_timeout = timeout_q;
`else
    logic unused_calib_to;

    assign unused_calib_to = ^CalibLast;
    assign calib_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Self-checking bench for fpga_rst_seq: directed sequencing scenarios plus randomized
// stimulus, every cycle compared against a behavioural phase/time model.
module tb_fpga_rst_seq;
    localparam int unsigned PERST_CYC = 8;
    localparam int unsigned PHY_CYC   = 4;
    localparam int unsigned CALIB_TO  = 16;

    localparam int S_RESET = 0;
    localparam int S_PERST = 1;
    localparam int S_CALIB = 2;
    localparam int S_ARMED = 3;
    localparam int S_PHY   = 4;
    localparam int S_RUN   = 5;
    localparam int S_FAULT = 6;

`ifdef FPGA_RST_SEQ_CALIB_TO_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       sys_clk_i   = 1'b0;
    logic       sys_rstn    = 1'b0;
    logic       enable      = 1'b0;
    logic       cpu_go      = 1'b0;
    logic       cpu_rst_req = 1'b0;
    logic       calib_done  = 1'b0;
    logic       perst_n;
    logic       phy_rstn;
    logic       cpu_rstn;
    logic [2:0] seq_state;
    logic       calib_timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Model: current phase, cycles spent in it (1 on entry), last two calib_done samples.
    int     m_state;
    int     m_time;
    bit     m_flag;
    bit [1:0] m_hist;

    always #5 sys_clk_i = ~sys_clk_i;

    fpga_rst_seq #(
        .PERST_CYC (PERST_CYC),
        .PHY_CYC   (PHY_CYC),
        .CALIB_TO  (CALIB_TO)
    ) dut (
        .sys_clk_i     (sys_clk_i),
        .sys_rstn      (sys_rstn),
        .enable        (enable),
        .cpu_go        (cpu_go),
        .cpu_rst_req   (cpu_rst_req),
        .calib_done    (calib_done),
        .perst_n       (perst_n),
        .phy_rstn      (phy_rstn),
        .cpu_rstn      (cpu_rstn),
        .seq_state     (seq_state),
        .calib_timeout (calib_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_RESET;
        m_time  = 1;
        m_hist  = 2'b00;
        m_flag  = 1'b0;
    endtask

    task automatic model_step();
        int nxt;
        bit cs;
        if (!sys_rstn) begin
            model_reset();
            return;
        end
        cs  = m_hist[1];
        nxt = m_state;
        if (!enable) begin
            nxt = S_RESET;
        end else begin
            case (m_state)
                S_RESET: nxt = S_PERST;
                S_PERST: if (m_time == int'(PERST_CYC)) nxt = S_CALIB;
                S_CALIB: begin
                    if (cs) nxt = S_ARMED;
                    else if (TO_EN && m_time == int'(CALIB_TO)) nxt = S_FAULT;
                end
                S_ARMED, S_PHY, S_RUN: begin
                    if (!cs) nxt = S_CALIB;
                    else if (m_state == S_ARMED && cpu_go) nxt = S_PHY;
                    else if (m_state == S_PHY && m_time == int'(PHY_CYC)) nxt = S_RUN;
                    else if (m_state == S_RUN && cpu_rst_req) nxt = S_ARMED;
                end
                default: ;
            endcase
        end
        if (nxt == S_FAULT) m_flag = 1'b1;
        if (nxt == m_state) begin
            m_time++;
        end else begin
            m_state = nxt;
            m_time  = 1;
        end
        m_hist = {m_hist[0], calib_done};
    endtask

    task automatic check_all(input string ph);
        check_eq({ph, ".state"}, 32'(seq_state), m_state);
        check_eq({ph, ".perst_n"}, 32'(perst_n), 32'(m_state >= S_CALIB));
        check_eq({ph, ".phy_rstn"}, 32'(phy_rstn), 32'(m_state == S_PHY || m_state == S_RUN));
        check_eq({ph, ".cpu_rstn"}, 32'(cpu_rstn), 32'(m_state == S_RUN));
        check_eq({ph, ".calib_timeout"}, 32'(calib_timeout), 32'(m_flag));
    endtask

    task automatic tick(input string ph);
        @(posedge sys_clk_i);
        model_step();
        #1;
        check_all(ph);
    endtask

    task automatic run_until(input string tag, input int target, input int budget, output int n);
        n = 0;
        do begin
            tick(tag);
            n++;
        end while (int'(seq_state) != target && n < budget);
        if (int'(seq_state) != target) check_eq({tag, ".reach"}, 32'(seq_state), target);
    endtask

    initial begin
        int n;
        model_reset();
        enable = 1'b1;
        #3;
        check_all("reset");
        #9;
        sys_rstn = 1'b1;

        // Power-up
        run_until("pwr.to_perst", S_PERST, 5, n);
        run_until("pwr.perst", S_CALIB, 30, n);
        check_eq("pwr.perst_len", n, 8);
        calib_done = 1'b1;
        run_until("pwr.calib", S_ARMED, 30, n);
        check_eq("pwr.calib_len", n, 3);
        cpu_go = 1'b1;
        tick("pwr.go");
        cpu_go = 1'b0;
        check_eq("pwr.phy_next", 32'(phy_rstn), 1);
        run_until("pwr.phy", S_RUN, 30, n);
        check_eq("pwr.phy_len", n, 4);
        check_eq("pwr.cpu_up", 32'(cpu_rstn), 1);

        // Soft reset
        repeat (3) tick("run");
        cpu_rst_req = 1'b1;
        tick("soft.req");
        cpu_rst_req = 1'b0;
        check_eq("soft.cpu_rstn", 32'(cpu_rstn), 0);
        check_eq("soft.phy_rstn", 32'(phy_rstn), 0);
        check_eq("soft.state", 32'(seq_state), S_ARMED);
        check_eq("soft.perst_n", 32'(perst_n), 1);
        cpu_go = 1'b1;
        tick("soft.go");
        cpu_go = 1'b0;
        run_until("soft.phy", S_RUN, 30, n);
        check_eq("soft.phy_len", n, 4);

        // Calibration loss with cpu_rst_req landing when calib_s drops
        calib_done = 1'b0;
        tick("loss.1");
        tick("loss.2");
        cpu_rst_req = 1'b1;
        tick("loss.3");
        cpu_rst_req = 1'b0;
        check_eq("loss.state", 32'(seq_state), S_CALIB);
        check_eq("loss.cpu_rstn", 32'(cpu_rstn), 0);

        // Enable drop during PHY
        calib_done = 1'b1;
        run_until("drop.arm", S_ARMED, 30, n);
        cpu_go = 1'b1;
        tick("drop.go");
        cpu_go = 1'b0;
        tick("drop.phy");
        enable     = 1'b0;
        calib_done = 1'b0;
        tick("drop.en0");
        enable = 1'b1;
        check_eq("drop.state", 32'(seq_state), S_RESET);
        check_eq("drop.outs", {29'd0, perst_n, phy_rstn, cpu_rstn}, 0);
        run_until("drop.to_perst", S_PERST, 5, n);
        run_until("drop.perst", S_CALIB, 30, n);
        check_eq("drop.perst_len", n, 8);

        // Calibration never completes
        if (TO_EN) begin
            run_until("to.wait", S_FAULT, 40, n);
            check_eq("to.len", n, 16);
            check_eq("to.flag", 32'(calib_timeout), 1);
            check_eq("to.perst_n", 32'(perst_n), 1);
            calib_done = 1'b1;
            repeat (5) tick("to.stay");
            check_eq("to.stay_state", 32'(seq_state), S_FAULT);
            enable = 1'b0;
            tick("to.en0");
            enable = 1'b1;
        end else begin
            repeat (1000) tick("to.wait");
            check_eq("to.state", 32'(seq_state), S_CALIB);
            check_eq("to.flag", 32'(calib_timeout), 0);
            calib_done = 1'b1;
        end

        // Async reset mid-RUN, off the clock edge
        run_until("ar.arm", S_ARMED, 40, n);
        cpu_go = 1'b1;
        tick("ar.go");
        cpu_go = 1'b0;
        run_until("ar.run", S_RUN, 20, n);
        #2;
        sys_rstn = 1'b0;
        #1;
        check_eq("ar.state", 32'(seq_state), 0);
        check_eq("ar.outs", {29'd0, perst_n, phy_rstn, cpu_rstn}, 0);
        check_eq("ar.flag", 32'(calib_timeout), 0);
        model_reset();
        tick("ar.hold");
        tick("ar.hold");
        sys_rstn = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            enable      = ($urandom_range(0, 49) != 0);
            cpu_go      = ($urandom_range(0, 5) == 0);
            cpu_rst_req = ($urandom_range(0, 19) == 0);
            sys_rstn    = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) calib_done = ~calib_done;
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
